mem_port_arbiter: RTL and testbench

//  Shares one physical memory port between instruction fetch (I) and load/store (D) requesters.

---
 rtl/rv32i_types.sv | 50 +++++
 rtl/mem_req_reg.sv | 31 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I type package.
// Provides the memory word and byte-mask types, the memory-port arbiter
// state encoding, the latched memory request record, and helpers that
// build a request from either requester's inputs.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_SERVE_I = 2'd1,
    ARB_SERVE_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic           read;
    logic           write;
    rv32i_word      addr;
    rv32i_word      wdata;
    rv32i_mem_wmask wmask;
  } mem_req_t;

  localparam mem_req_t MEM_REQ_NONE = '0;

  // A simultaneous read+write request is a store; the read strobe is dropped
  // here so the memory side never sees both strobes at once.
  function automatic mem_req_t build_d_req(input logic           rd,
                                           input logic           wr,
                                           input rv32i_word      addr,
                                           input rv32i_word      wdata,
                                           input rv32i_mem_wmask wmask);
    mem_req_t r;
    r.read  = rd & ~wr;
    r.write = wr;
    r.addr  = addr;
    r.wdata = wdata;
    r.wmask = wmask;
    return r;
  endfunction

  function automatic mem_req_t build_i_req(input rv32i_word addr);
    mem_req_t r;
    r       = MEM_REQ_NONE;
    r.read  = 1'b1;
    r.addr  = addr;
    return r;
  endfunction

endpackage

// File: rtl/mem_req_reg.sv
// Grant latch for the memory-port arbiter.
// Holds one mem_req_t; loads d_i when ld_i is high, otherwise holds.
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset (clears the request)
//   ld_i  in   load enable
//   d_i   in   request to load
//   q_o   out  latched request
module mem_req_reg
  import rv32i_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ld_i,
  input  mem_req_t d_i,
  output mem_req_t q_o
);

  mem_req_t req_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= MEM_REQ_NONE;
    end else if (ld_i) begin
      req_q <= d_i;
    end
  end

  assign q_o = req_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Memory-port arbiter: shares one memory port between instruction fetch (I)
// and load/store (D). D has priority, but after MAX_D_STREAK consecutive D
// grants made while fetch was waiting, the next grant goes to fetch.
// The granted request is latched and drives the memory port unchanged until
// mem_resp; the response is forwarded combinationally in that cycle.
// Ports:
//   clk, rst_n                      clock / asynchronous active-low reset
//   i_read, i_addr                  fetch request (held until i_resp)
//   i_rdata, i_resp                 fetch response
//   d_read, d_write, d_addr,
//   d_wdata, d_wmask                load/store request (held until d_resp)
//   d_rdata, d_resp                 load/store response
//   mem_read, mem_write, mem_addr,
//   mem_wdata, mem_wmask            registered memory request
//   mem_rdata, mem_resp             memory response
//   grant_d                         high while a D transaction owns the port
module mem_port_arbiter
  import rv32i_types::*;
#(
  parameter int MAX_D_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        grant_d
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t    state_q;
  logic [SW-1:0] streak_q;

  logic     d_req_w;
  logic     i_forced_w;
  logic     take_d_w;
  logic     take_i_w;
  logic     done_w;
  logic     req_ld_w;
  mem_req_t req_d_w;
  mem_req_t req_q;

  assign d_req_w    = d_read | d_write;
  // Fetch has waited through a full D streak: it must win this time.
  assign i_forced_w = i_read && (streak_q == STREAK_MAX);
  assign take_d_w   = (state_q == ARB_IDLE) && d_req_w && !i_forced_w;
  assign take_i_w   = (state_q == ARB_IDLE) && !take_d_w && i_read;
  assign done_w     = (state_q != ARB_IDLE) && mem_resp;

  // The latch is cleared on completion so the memory strobes drop in the
  // following IDLE cycle without any decoding on the output path.
  assign req_ld_w = take_d_w | take_i_w | done_w;
  always_comb begin
    req_d_w = MEM_REQ_NONE;
    if (take_d_w) begin
      req_d_w = build_d_req(d_read, d_write, d_addr, d_wdata, d_wmask);
    end else if (take_i_w) begin
      req_d_w = build_i_req(i_addr);
    end
  end

  mem_req_reg u_req_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .ld_i  (req_ld_w),
    .d_i   (req_d_w),
    .q_o   (req_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      streak_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (take_d_w) begin
            state_q <= ARB_SERVE_D;
            if (!i_read) begin
              streak_q <= '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_q <= streak_q + 1'b1;
            end
          end else if (take_i_w) begin
            state_q  <= ARB_SERVE_I;
            streak_q <= '0;
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          if (mem_resp) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_read  = req_q.read;
  assign mem_write = req_q.write;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_wmask = req_q.wmask;
  assign grant_d   = (state_q == ARB_SERVE_D);

  // mem_resp seen in IDLE belongs to nobody and is dropped here.
  assign i_resp  = (state_q == ARB_SERVE_I) && mem_resp;
  assign d_resp  = (state_q == ARB_SERVE_D) && mem_resp;
  assign i_rdata = i_resp ? mem_rdata : 32'h0;
  assign d_rdata = d_resp ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wmask;
  logic [31:0] d_rdata;
  logic        d_resp;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        grant_d;

  int n_vec = 0;
  int n_err = 0;

  mem_port_arbiter #(.MAX_D_STREAK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_read    (i_read),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .grant_d   (grant_d)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the request already driven. Waits for the port
  // to become busy, checks the latched request every cycle, answers after
  // lat busy cycles with rd, then checks the IDLE gap cycle.
  task automatic run_txn(input string tag, input bit exp_d, input bit exp_wr,
                         input logic [31:0] ea, input logic [31:0] ew,
                         input logic [3:0] em, input int lat,
                         input logic [31:0] rd, input bit drop,
                         input bit chg, input logic [31:0] chg_addr);
    int n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "/busy"}, 32'(mem_read || mem_write), 32'd1);
    for (int c = 1; c <= lat; c++) begin
      if (c == lat) begin
        mem_resp  = 1'b1;
        mem_rdata = rd;
      end else begin
        mem_rdata = 32'hBAD0_0000 | 32'(c);
      end
      #1;
      chk({tag, "/grant_d"}, 32'(grant_d), 32'(exp_d));
      chk({tag, "/mem_write"}, 32'(mem_write), 32'(exp_wr));
      chk({tag, "/mem_read"}, 32'(mem_read), 32'(!exp_wr));
      chk({tag, "/mem_addr"}, mem_addr, ea);
      if (exp_wr) begin
        chk({tag, "/mem_wdata"}, mem_wdata, ew);
        chk({tag, "/mem_wmask"}, 32'(mem_wmask), 32'(em));
      end
      chk({tag, "/i_resp"}, 32'(i_resp), 32'(c == lat && !exp_d));
      chk({tag, "/d_resp"}, 32'(d_resp), 32'(c == lat && exp_d));
      chk({tag, "/i_rdata"}, i_rdata, (c == lat && !exp_d) ? rd : 32'h0);
      chk({tag, "/d_rdata"}, d_rdata, (c == lat && exp_d) ? rd : 32'h0);
      if (chg && c == 1) d_addr = chg_addr;
      @(negedge clk);
    end
    mem_resp  = 1'b0;
    mem_rdata = 32'h0;
    #1;
    chk({tag, "/idle_rd"}, 32'(mem_read), 32'd0);
    chk({tag, "/idle_wr"}, 32'(mem_write), 32'd0);
    chk({tag, "/idle_gd"}, 32'(grant_d), 32'd0);
    if (drop) begin
      if (exp_d) begin
        d_read  = 1'b0;
        d_write = 1'b0;
      end else begin
        i_read = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/mem_read", 32'(mem_read), 0);
    chk("rst/mem_write", 32'(mem_write), 0);
    chk("rst/mem_addr", mem_addr, 0);
    chk("rst/mem_wdata", mem_wdata, 0);
    chk("rst/mem_wmask", 32'(mem_wmask), 0);
    chk("rst/grant_d", 32'(grant_d), 0);
    chk("rst/resp", 32'({i_resp, d_resp}), 0);
    chk("rst/rdata", i_rdata | d_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single fetch, 3-cycle memory
    i_read = 1'b1; i_addr = 32'h60;
    run_txn("t1", 0, 0, 32'h60, 0, 0, 3, 32'h0000_0013, 1, 0, 0);

    // 2: fetch and store together, store first, fetch after one IDLE cycle
    i_read = 1'b1; i_addr = 32'h40;
    d_write = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'hF;
    run_txn("t2d", 1, 1, 32'h100, 32'hDEAD_BEEF, 4'hF, 1, 32'h0, 1, 0, 0);
    run_txn("t2i", 0, 0, 32'h40, 0, 0, 1, 32'h1111_2222, 1, 0, 0);

    // 3: D streak of four then forced I, then D again
    i_read = 1'b1; i_addr = 32'h80;
    d_read = 1'b1; d_addr = 32'h200;
    for (int k = 0; k < 4; k++)
      run_txn($sformatf("t3d%0d", k), 1, 0, 32'h200, 0, 0, 1, 32'hA000_0000 + 32'(k), 0, 0, 0);
    run_txn("t3i", 0, 0, 32'h80, 0, 0, 1, 32'h0000_0093, 1, 0, 0);
    run_txn("t3d4", 1, 0, 32'h200, 0, 0, 2, 32'hA000_0004, 1, 0, 0);

    // 4: d_addr changed mid-transaction has no effect
    d_read = 1'b1; d_addr = 32'h100;
    run_txn("t4", 1, 0, 32'h100, 0, 0, 3, 32'h5555_AAAA, 1, 1, 32'h200);

    // 5: reset during SERVE_I with mem_resp pending
    i_read = 1'b1; i_addr = 32'h84;
    n = 0;
    while (!mem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5/busy", 32'(mem_read), 1);
    mem_resp = 1'b1; mem_rdata = 32'hCAFE_F00D; rst_n = 1'b0;
    #1;
    chk("t5/i_resp", 32'(i_resp), 0);
    chk("t5/i_rdata", i_rdata, 0);
    chk("t5/mem_read", 32'(mem_read), 0);
    chk("t5/mem_addr", mem_addr, 0);
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = 32'h0; rst_n = 1'b1;
    run_txn("t5i", 0, 0, 32'h84, 0, 0, 1, 32'h0000_0033, 1, 0, 0);

    // 6: read+write together is a write; spurious mem_resp in IDLE ignored
    d_read = 1'b1; d_write = 1'b1; d_addr = 32'h300; d_wdata = 32'h1234_5678; d_wmask = 4'h3;
    run_txn("t6", 1, 1, 32'h300, 32'h1234_5678, 4'h3, 2, 32'h0, 1, 0, 0);
    mem_resp = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    chk("t6/spur_i_resp", 32'(i_resp), 0);
    chk("t6/spur_d_resp", 32'(d_resp), 0);
    chk("t6/spur_rdata", i_rdata | d_rdata, 0);
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = 32'h0;
    chk("t6/spur_idle", 32'({mem_read, mem_write, grant_d}), 0);

    // Store with zero byte mask is forwarded unchanged
    d_write = 1'b1; d_addr = 32'h304; d_wdata = 32'h0BAD_F00D; d_wmask = 4'h0;
    run_txn("t7", 1, 1, 32'h304, 32'h0BAD_F00D, 4'h0, 1, 32'h0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
